// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Shares the single write port of the 32x32 register file between two
// writeback sources:
//   - source A: in-order pipeline WB stage, always wins the port and cannot
//     be back-pressured.
//   - source B: long-latency unit (divider, load-miss path). Its results are
//     buffered in a small FIFO and drained into cycles where A leaves the
//     port free (wb_valid=0, or a write to x0).
// A pending-register scoreboard (x1..x31) tells ID which registers still
// await a source-B result. A starvation FSM (IDLE/BLOCKED/STALL) raises
// pipe_stall when the FIFO head has been blocked for STARVE_LIMIT
// consecutive cycles, so WB can go quiet and let the FIFO drain.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   - a source-B result accepted while the FIFO is empty and the
//               port is free commits in the same cycle, skipping the FIFO.
//   undefined - every source-B result passes through the FIFO.
//
// Parameters:
//   DEPTH        source-B FIFO entries (power of two, 2..8)
//   STARVE_LIMIT consecutive blocked cycles before pipe_stall (1..15)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wb_valid/wb_rd/wb_data     source A write request
//   lu_valid/lu_rd/lu_data     source B result, lu_ready = accepted
//   lu_issue/lu_issue_rd       long-latency op issued (scoreboard set)
//   rs1/rs2/rd                 ID-stage indices; busy1/busy2/busy_rd flags
//   pipe_stall                 request for the pipeline to freeze WB
//   rf_we/rf_waddr/rf_wdata    register file write port

`default_nettype none

module regfile_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    input  logic        lu_issue,
    input  logic [4:0]  lu_issue_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    output logic        busy1,
    output logic        busy2,
    output logic        busy_rd,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, BLOCKED, STALL} state_t;

    // FIFO storage: {rd, data}; small enough for distributed RAM, read
    // asynchronously so the head can commit in the cycle it is popped.
    logic [36:0]      fifoMem [DEPTH];
    logic [PTR_W-1:0] wrPtrReg;
    logic [PTR_W-1:0] rdPtrReg;
    logic [CNT_W-1:0] countReg;

    logic [31:1] pendingReg;
    logic [31:1] pendingNext;
    logic [31:0] pendingVec;

    state_t     stateReg;
    state_t     stateNext;
    logic [3:0] starveCntReg;
    logic [3:0] starveCntNext;

    logic        portFree;
    logic        fifoEmpty;
    logic        fifoPush;
    logic        fifoPop;
    logic        luBypass;
    logic        blocked;
    logic        commitB;
    logic [4:0]  commitRd;
    logic [4:0]  headRd;
    logic [31:0] headData;

    assign fifoEmpty = (countReg == '0);
    // Ready depends on registered occupancy only; a pop in the same cycle
    // does not free a slot for the incoming result.
    assign lu_ready  = (countReg != CNT_W'(DEPTH));
    // A write to x0 is a no-op, so it leaves the port free for source B.
    assign portFree  = !wb_valid || (wb_rd == 5'd0);
    assign fifoPop   = portFree && !fifoEmpty;
    assign blocked   = !fifoEmpty && !fifoPop;
    assign {headRd, headData} = fifoMem[rdPtrReg];

`ifdef WB_BYPASS_EN
    assign luBypass = lu_valid && lu_ready && fifoEmpty && portFree;
`else
    assign luBypass = 1'b0;
`endif

    assign fifoPush = lu_valid && lu_ready && !luBypass;
    assign commitB  = fifoPop || luBypass;
    assign commitRd = fifoPop ? headRd : lu_rd;

    // Write port grant: A first, then FIFO head, then bypassed B result.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (wb_valid && (wb_rd != 5'd0)) begin
            rf_we    = 1'b1;
            rf_waddr = wb_rd;
            rf_wdata = wb_data;
        end else if (fifoPop) begin
            rf_we    = (headRd != 5'd0);
            rf_waddr = headRd;
            rf_wdata = headData;
        end else if (luBypass) begin
            rf_we    = (lu_rd != 5'd0);
            rf_waddr = lu_rd;
            rf_wdata = lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (fifoPush) begin
            fifoMem[wrPtrReg] <= {lu_rd, lu_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtrReg   <= '0;
            rdPtrReg   <= '0;
            countReg   <= '0;
            pendingReg <= '0;
        end else begin
            if (fifoPush) begin
                wrPtrReg <= wrPtrReg + PTR_W'(1);
            end
            if (fifoPop) begin
                rdPtrReg <= rdPtrReg + PTR_W'(1);
            end
            if (fifoPush && !fifoPop) begin
                countReg <= countReg + CNT_W'(1);
            end else if (!fifoPush && fifoPop) begin
                countReg <= countReg - CNT_W'(1);
            end
            pendingReg <= pendingNext;
        end
    end

    // Scoreboard: an issue to the same register as a committing B entry
    // wins, since it describes a newer outstanding result.
    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_sb
            assign pendingNext[gi] =
                (lu_issue && (lu_issue_rd == 5'(gi))) ||
                (pendingReg[gi] && !(commitB && (commitRd == 5'(gi))));
        end
    endgenerate

    assign pendingVec = {pendingReg, 1'b0};
    assign busy1      = pendingVec[rs1];
    assign busy2      = pendingVec[rs2];
    assign busy_rd    = pendingVec[rd];

    // Starvation FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg     <= IDLE;
            starveCntReg <= 4'd0;
        end else begin
            stateReg     <= stateNext;
            starveCntReg <= starveCntNext;
        end
    end

    // Starvation FSM: next state. Any unblocked cycle (head popped or FIFO
    // empty) returns to IDLE. The stall is entered on the edge where the
    // count reaches the limit, so pipe_stall shows the following cycle.
    always_comb begin
        stateNext     = stateReg;
        starveCntNext = starveCntReg;
        case (stateReg)
            IDLE: begin
                if (blocked) begin
                    starveCntNext = 4'd1;
                    stateNext     = (STARVE_LIMIT == 1) ? STALL : BLOCKED;
                end
            end
            BLOCKED: begin
                if (!blocked) begin
                    stateNext     = IDLE;
                    starveCntNext = 4'd0;
                end else begin
                    starveCntNext = starveCntReg + 4'd1;
                    if ((starveCntReg + 4'd1) == 4'(STARVE_LIMIT)) begin
                        stateNext = STALL;
                    end
                end
            end
            STALL: begin
                if (!blocked) begin
                    stateNext     = IDLE;
                    starveCntNext = 4'd0;
                end
            end
            default: begin
                stateNext     = IDLE;
                starveCntNext = 4'd0;
            end
        endcase
    end

    // Starvation FSM: outputs.
    always_comb begin
        pipe_stall = (stateReg == STALL);
    end

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 32×32 register file between two writeback sources: the in-order pipeline WB stage (source A) and a long-latency unit such as a divider or load miss path (source B). Source B results are buffered in a small FIFO and drained into idle port cycles. A pending-register scoreboard tells the ID stage which registers still await a source-B result. A starvation counter forces a pipeline stall when the FIFO cannot drain.

## Interface
Parameters:
- DEPTH, 2, source-B FIFO entries (power of two, 2..8)
- STARVE_LIMIT, 4, consecutive blocked cycles before pipe_stall asserts (1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  source A write request (cannot be back-pressured)
- wb_rd  in  5  source A destination register
- wb_data  in  32  source A write data
- lu_valid  in  1  source B result valid
- lu_ready  out  1  source B result accepted this cycle
- lu_rd  in  5  source B destination register
- lu_data  in  32  source B result data
- lu_issue  in  1  long-latency op issued this cycle (scoreboard set)
- lu_issue_rd  in  5  destination of issued op
- rs1, rs2, rd  in  5 each  ID-stage register indices to check
- busy1, busy2, busy_rd  out  1 each  corresponding register pending a source-B write
- pipe_stall  out  1  registered request for pipeline to freeze so WB presents wb_valid=0
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data

## Operation
- Port priority: source A always wins. rf_* driven combinationally from the grant.
- Source B path: push when lu_valid && lu_ready; lu_ready = (count != DEPTH), from registered count only (no same-cycle pop credit).
- Pop FIFO head when wb_valid=0, or wb_valid=1 with wb_rd=0 (A's write is a no-op, port free).
- Writes to x0 from either source: rf_we=0; a B entry targeting x0 still pops.
- Scoreboard: 31 bits (x1..x31). Set on lu_issue for lu_issue_rd≠0; cleared when a B entry for that register commits. Same register set and cleared in one cycle: set wins. busy1/busy2/busy_rd combinational; x0 always 0.
- ID stalls on any busy bit; guarantees no WAW/RAW between sources.
- Starvation FSM, states IDLE, BLOCKED, STALL:
  - IDLE→BLOCKED: FIFO non-empty and head not popped; starve_cnt=1.
  - BLOCKED: increment each blocked cycle; pop → IDLE, cnt=0; cnt reaches STARVE_LIMIT → STALL.
  - STALL: pipe_stall=1; on head pop → IDLE, cnt=0, pipe_stall deasserts next cycle.
  - FIFO empty in any state → IDLE.

## Timing
- Reset values: FIFO empty, count 0, lu_ready 1, scoreboard all 0, busy* 0, FSM IDLE, starve_cnt 0, pipe_stall 0, rf_we 0 (with no inputs), rf_waddr 0, rf_wdata 0.
- Source A: zero latency, same-cycle rf_we.
- Source B (buffered): pushed cycle N, earliest commit cycle N+1; busy bit clears at edge ending commit cycle.
- pipe_stall: asserts the cycle after cnt reaches STARVE_LIMIT.
- Wrap-around: read/write pointers log2(DEPTH) bits wrapping naturally; count separate, DEPTH+1 values.
- Full: lu_ready=0 even if pop occurs same cycle.
- Reset mid-operation: buffered results and scoreboard discarded immediately; upstream flushes too.

## Configuration
- WB_BYPASS_EN defined: when FIFO empty and port free (wb_valid=0 or wb_rd=0), an accepted source-B result commits same cycle without entering FIFO; scoreboard bit clears same edge.
- Undefined: every source-B result passes through FIFO; minimum one cycle latency.

## Test plan
- Reset: assert rst_n=0 mid-traffic → next sample lu_ready=1, busy*=0, pipe_stall=0, FIFO empty.
- Idle B write: lu_issue rd=5, later lu_valid rd=5 data=0xDEADBEEF, wb_valid=0 → rf_we at N+1 (N with WB_BYPASS_EN), x5 written, busy for rd=5 clears.
- Conflict: wb_valid rd=3 data=1 and lu_valid rd=7 data=2 same cycle → x3 written first, x7 next idle cycle.
- Full: DEPTH=2, wb_valid held 1 with rd≠0, three lu_valid → third sees lu_ready=0; pipe_stall after STARVE_LIMIT=4 blocked cycles; drop wb_valid → head pops, pipe_stall clears next cycle.
- x0: wb_rd=0 while FIFO holds rd=9 → B commits that cycle; lu_rd=0 entry → pops with rf_we=0.
- Scoreboard race: lu_issue rd=12 in same cycle as B commit to x12 → busy for x12 stays 1.
